// File: rtl/freq_meas_sched.sv
// Sequential multi-channel frequency meter: counts rising edges of each
// masked channel over a fixed gate window and reports one result per channel.
module freq_meas_sched #(
    parameter int Bits    = 16,
    parameter int GateLen = 1000,
    parameter int Chans   = 4,
    localparam int ChanW  = (Chans > 1) ? $clog2(Chans) : 1
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic             Start,
    input  logic [Chans-1:0] ChanMask,
    input  logic [Chans-1:0] Signals,
    output logic             Busy,
    output logic             Done,
    output logic [Bits-1:0]  Result,
    output logic [ChanW-1:0] ResultChan,
    output logic             ResultValid,
    output logic             Overflow
);

    localparam int GW = (GateLen > 2) ? $clog2(GateLen) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GATE,
        S_REPORT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [Chans-1:0] r_sync1;
    logic [Chans-1:0] r_sync2;
    logic [Chans-1:0] r_hist;
    logic [Chans-1:0] r_mask;
    logic [ChanW-1:0] r_sel;
    logic [GW-1:0]    r_gate;
    logic [Bits-1:0]  r_cnt;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;
    logic             r_valid;
    logic [Bits-1:0]  r_result;
    logic [ChanW-1:0] r_rchan;
    logic             r_ovf_out;

    logic [Chans-1:0] w_pulse;
    logic             w_edge;
    logic             w_sat;
    logic [Bits-1:0]  w_cnt_next;
    logic             w_ovf_next;
    logic [ChanW-1:0] w_first;
    logic             w_has_first;
    logic [ChanW-1:0] w_next;
    logic             w_has_next;

    // Every channel keeps its own history, so switching channels never fakes an edge.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_hist  <= '0;
        end else begin
            r_sync1 <= Signals;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_pulse    = r_sync2 & ~r_hist;
    assign w_edge     = w_pulse[r_sel];
    assign w_sat      = &r_cnt;
    assign w_cnt_next = (w_edge && !w_sat) ? r_cnt + 1'b1 : r_cnt;
    assign w_ovf_next = r_ovf | (w_edge & w_sat);

    always_comb begin
        w_first     = '0;
        w_has_first = 1'b0;
        w_next      = '0;
        w_has_next  = 1'b0;
        for (int i = Chans - 1; i >= 0; i--) begin
            if (ChanMask[i]) begin
                w_first     = ChanW'(i);
                w_has_first = 1'b1;
            end
            if (r_mask[i] && (i > int'(r_sel))) begin
                w_next     = ChanW'(i);
                w_has_next = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state   <= S_IDLE;
            r_mask    <= '0;
            r_sel     <= '0;
            r_gate    <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_rchan   <= '0;
            r_ovf_out <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_mask <= ChanMask;
                        r_busy <= 1'b1;
                        if (w_has_first) begin
                            r_sel   <= w_first;
                            r_gate  <= '0;
                            r_cnt   <= '0;
                            r_ovf   <= 1'b0;
                            r_state <= S_GATE;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_GATE: begin
                    r_gate <= r_gate + 1'b1;
                    r_cnt  <= w_cnt_next;
                    r_ovf  <= w_ovf_next;
                    // Last gate cycle still counts, so report the updated totals.
                    if (r_gate == GW'(GateLen - 1)) begin
                        r_result  <= w_cnt_next;
                        r_rchan   <= r_sel;
                        r_ovf_out <= w_ovf_next;
                        r_valid   <= 1'b1;
                        r_state   <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (w_has_next) begin
                        r_sel   <= w_next;
                        r_gate  <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= S_GATE;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Busy        = r_busy;
    assign Done        = r_done;
    assign Result      = r_result;
    assign ResultChan  = r_rchan;
    assign ResultValid = r_valid;
    assign Overflow    = r_ovf_out;

endmodule
